// File: rtl/ethpipe_tx.sv
// GMII frame transmitter: streams one frame from the TX slot RAM as
// preamble, SFD, data, zero pad, FCS, then holds the inter-frame gap.
module ethpipe_tx #(
  parameter logic [10:0] BASE_ADDR = 11'd0,
  parameter logic [11:0] MIN_LEN   = 12'd60,
  parameter int          IFG_LEN   = 12
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic [63:0] global_counter,
  input  logic        tx_start,
  input  logic [11:0] tx_frame_len,
  output logic        tx_busy,
  output logic        tx_done,
  output logic [63:0] tx_timestamp,
  output logic [10:0] slot_tx_eth_address,
  output logic        slot_tx_eth_rd_en,
  input  logic [31:0] slot_tx_eth_q,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] len_q, len_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] buf_q, buf_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [63:0] ts_q, ts_d;
  logic [10:0] addr_q, addr_d;
  logic        rd_q, rd_d;

  logic [11:0] nxt;
  logic [10:0] word;
  logic [1:0]  lane;
  logic [7:0]  dbyte;
  logic [31:0] fcs;
  logic        crc_en;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign nxt  = cnt_q + 12'd1;
  assign word = {1'b0, cnt_q[11:2]} + 11'd1;
  assign lane = nxt[1:0];
  // Lane 0 comes straight from the RAM; the word is kept for lanes 1..3.
  assign dbyte = (lane == 2'd0) ? slot_tx_eth_q[7:0]
                                : buf_q[{lane, 3'b000} +: 8];
  assign fcs  = ~crc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    crc_d   = crc_q;
    buf_d   = buf_q;
    txd_d   = txd_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ts_d    = ts_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    crc_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          if (tx_frame_len != 12'd0) begin
            state_d = S_PRE;
            cnt_d   = 12'd0;
            len_d   = tx_frame_len;
            busy_d  = 1'b1;
            txd_d   = 8'h55;
            en_d    = 1'b1;
            crc_d   = 32'hFFFFFFFF;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PRE: begin
        cnt_d = nxt;
        if (cnt_q == 12'd5) begin
          rd_d   = 1'b1;
          addr_d = BASE_ADDR;
        end
        if (cnt_q == 12'd6) begin
          state_d = S_SFD;
          txd_d   = 8'hD5;
        end
      end
      S_SFD: begin
        state_d = S_DATA;
        cnt_d   = 12'd0;
        ts_d    = global_counter;
        txd_d   = slot_tx_eth_q[7:0];
        buf_d   = slot_tx_eth_q;
        crc_en  = 1'b1;
      end
      S_DATA: begin
        cnt_d = nxt;
        // Fetch word w two cycles before its lane-0 byte is needed.
        if (cnt_q[1:0] == 2'd1 && {word, 2'b00} < {1'b0, len_q}) begin
          rd_d   = 1'b1;
          addr_d = BASE_ADDR + word;
        end
        if (nxt < len_q) begin
          txd_d  = dbyte;
          crc_en = 1'b1;
          if (lane == 2'd0) buf_d = slot_tx_eth_q;
        end else if (nxt < MIN_LEN) begin
          state_d = S_PAD;
          txd_d   = 8'h00;
          crc_en  = 1'b1;
        end else begin
          state_d = S_FCS;
          cnt_d   = 12'd0;
          txd_d   = fcs[7:0];
        end
      end
      S_PAD: begin
        cnt_d = nxt;
        if (nxt < MIN_LEN) begin
          txd_d  = 8'h00;
          crc_en = 1'b1;
        end else begin
          state_d = S_FCS;
          cnt_d   = 12'd0;
          txd_d   = fcs[7:0];
        end
      end
      S_FCS: begin
        cnt_d = nxt;
        if (cnt_q == 12'd3) begin
          state_d = S_IFG;
          cnt_d   = 12'd0;
          txd_d   = 8'h00;
          en_d    = 1'b0;
        end else begin
          txd_d = fcs[{lane, 3'b000} +: 8];
        end
      end
      S_IFG: begin
        cnt_d = nxt;
        if (cnt_q == 12'(IFG_LEN - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          addr_d  = BASE_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (crc_en) crc_d = crc_step(crc_q, txd_d);
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 12'd0;
      len_q   <= 12'd0;
      crc_q   <= 32'hFFFFFFFF;
      buf_q   <= 32'd0;
      txd_q   <= 8'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ts_q    <= 64'd0;
      addr_q  <= BASE_ADDR;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      buf_q   <= buf_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ts_q    <= ts_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
    end
  end

  assign gmii_txd            = txd_q;
  assign gmii_tx_en          = en_q;
  assign tx_busy             = busy_q;
  assign tx_done             = done_q;
  assign tx_timestamp        = ts_q;
  assign slot_tx_eth_address = addr_q;
  assign slot_tx_eth_rd_en   = rd_q;

endmodule

// File: tb/tb_ethpipe_tx.sv
// Directed bench for ethpipe_tx: one instance without padding, one with
// the default minimum length, both fed from a shared slot RAM model.
module tb_ethpipe_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] gc = 64'd0;

  logic        start_a, start_b;
  logic [11:0] len_a, len_b;
  logic        busy_a, busy_b, done_a, done_b, rd_a, rd_b, en_a, en_b;
  logic [63:0] ts_a, ts_b;
  logic [10:0] addr_a, addr_b;
  logic [31:0] q_a = 32'd0, q_b = 32'd0;
  logic [7:0]  txd_a, txd_b;

  logic [31:0] mem [0:2047];

  ethpipe_tx #(.MIN_LEN(12'd0)) u_a (
    .gmii_tx_clk(clk), .sys_rst(rst), .global_counter(gc),
    .tx_start(start_a), .tx_frame_len(len_a),
    .tx_busy(busy_a), .tx_done(done_a), .tx_timestamp(ts_a),
    .slot_tx_eth_address(addr_a), .slot_tx_eth_rd_en(rd_a),
    .slot_tx_eth_q(q_a), .gmii_txd(txd_a), .gmii_tx_en(en_a)
  );

  ethpipe_tx u_b (
    .gmii_tx_clk(clk), .sys_rst(rst), .global_counter(gc),
    .tx_start(start_b), .tx_frame_len(len_b),
    .tx_busy(busy_b), .tx_done(done_b), .tx_timestamp(ts_b),
    .slot_tx_eth_address(addr_b), .slot_tx_eth_rd_en(rd_b),
    .slot_tx_eth_q(q_b), .gmii_txd(txd_b), .gmii_tx_en(en_b)
  );

  always @(posedge clk) begin
    gc <= gc + 64'd1;
    if (rd_a) q_a <= mem[addr_a];
    if (rd_b) q_b <= mem[addr_b];
  end

  logic [7:0]  cap_a[$], cap_b[$], expq[$];
  logic [10:0] addrs_b[$];
  int en_a_n = 0, done_a_n = 0;
  int en_b_n = 0, rise_b_n = 0, done_b_n = 0;
  longint fall_b_t = 0, done_b_t = 0;
  bit pb = 1'b0;

  always @(negedge clk) begin
    if (en_a) begin cap_a.push_back(txd_a); en_a_n++; end
    if (done_a) done_a_n++;
    if (en_b) begin
      if (!pb) rise_b_n++;
      cap_b.push_back(txd_b);
      en_b_n++;
    end
    if (!en_b && pb) fall_b_t = longint'(gc);
    if (done_b) begin done_b_n++; done_b_t = longint'(gc); end
    if (rd_b) addrs_b.push_back(addr_b);
    pb = en_b;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_byte(input int n, input logic [7:0] v);
    mem[n / 4][(n % 4) * 8 +: 8] = v;
  endtask

  function automatic logic [7:0] get_byte(input int n);
    logic [31:0] w;
    w = mem[n / 4];
    return w[(n % 4) * 8 +: 8];
  endfunction

  task automatic build_exp(input int len, input int minlen);
    logic [31:0] c;
    logic [7:0]  b;
    int t;
    expq.delete();
    for (int i = 0; i < 7; i++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    t = (len > minlen) ? len : minlen;
    for (int n = 0; n < t; n++) begin
      b = (n < len) ? get_byte(n) : 8'h00;
      expq.push_back(b);
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) expq.push_back(c[k * 8 +: 8]);
  endtask

  task automatic cmp_frame(input string tag, input logic [7:0] cap[$],
                           input int s);
    int nerr;
    nerr = 0;
    check({tag, "_len"}, longint'(cap.size() - s), longint'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      if (s + i >= cap.size() || cap[s + i] !== expq[i]) nerr++;
    check({tag, "_bytes"}, longint'(nerr), 0);
  endtask

  task automatic wait_done_b(input string tag, input int base,
                             input int budget);
    int k;
    k = 0;
    while (done_b_n == base && k < budget) begin step(); k++; end
    check({tag, "_done_seen"}, longint'(done_b_n != base), 1);
  endtask

  task automatic pulse_b(input int len);
    start_b = 1'b1;
    len_b = 12'(len);
    step();
    start_b = 1'b0;
  endtask

  int s, e0, r0, d0, a0;
  longint g0;
  logic [7:0] t1[$];

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    len_a = 12'd0; len_b = 12'd0;
    repeat (3) step();
    check("rst_txd", longint'(txd_b), 0);
    check("rst_en", longint'(en_b), 0);
    check("rst_busy", longint'(busy_b), 0);
    check("rst_done", longint'(done_b), 0);
    check("rst_ts", longint'(ts_b), 0);
    check("rst_addr", longint'(addr_b), 0);
    check("rst_rd", longint'(rd_b), 0);
    rst = 1'b0;
    step();

    // 1: "123456789" without padding
    for (int i = 0; i < 9; i++) set_byte(i, 8'h31 + 8'(i));
    s = cap_a.size(); e0 = en_a_n; d0 = done_a_n;
    start_a = 1'b1; len_a = 12'd9;
    step();
    start_a = 1'b0;
    for (int k = 0; k < 100 && done_a_n == d0; k++) step();
    check("t1_done", longint'(done_a_n - d0), 1);
    expq = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
             8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    t1 = cap_a;
    cmp_frame("t1", t1, s);
    check("t1_en_cycles", longint'(en_a_n - e0), 21);

    // 2: 14-byte header padded to 60
    for (int i = 0; i < 14; i++) set_byte(i, 8'(i * 7 + 1));
    s = cap_b.size(); e0 = en_b_n; r0 = rise_b_n; d0 = done_b_n;
    pulse_b(14);
    check("t2_busy", longint'(busy_b), 1);
    wait_done_b("t2", d0, 200);
    build_exp(14, 60);
    cmp_frame("t2", cap_b, s);
    check("t2_en_cycles", longint'(en_b_n - e0), 72);
    check("t2_rise", longint'(rise_b_n - r0), 1);
    check("t2_gap", done_b_t - fall_b_t, 12);
    step();
    check("t2_done_once", longint'(done_b_n - d0), 1);
    check("t2_busy_end", longint'(busy_b), 0);
    check("t2_addr_end", longint'(addr_b), 0);
    check("t2_rd_end", longint'(rd_b), 0);

    // 3: max-size frame with incrementing bytes
    for (int i = 0; i < 1514; i++) set_byte(i, 8'(i));
    s = cap_b.size(); e0 = en_b_n; d0 = done_b_n; a0 = addrs_b.size();
    pulse_b(1514);
    wait_done_b("t3", d0, 2000);
    build_exp(1514, 60);
    cmp_frame("t3", cap_b, s);
    check("t3_en_cycles", longint'(en_b_n - e0), 1526);
    check("t3_reads", longint'(addrs_b.size() - a0), 379);
    begin
      int bad;
      bad = 0;
      for (int i = a0; i < addrs_b.size(); i++)
        if (int'(addrs_b[i]) != i - a0) bad++;
      check("t3_addr_seq", longint'(bad), 0);
    end

    // 4: timestamp, and a start pulse while busy is ignored
    for (int i = 0; i < 20; i++) set_byte(i, 8'($urandom_range(0, 255)));
    s = cap_b.size(); e0 = en_b_n; r0 = rise_b_n; d0 = done_b_n;
    pulse_b(20);
    g0 = longint'(gc);
    repeat (30) step();
    check("t4_ts", longint'(ts_b), g0 + 7);
    pulse_b(5);
    step();
    check("t4_ts_kept", longint'(ts_b), g0 + 7);
    wait_done_b("t4", d0, 200);
    build_exp(20, 60);
    cmp_frame("t4", cap_b, s);
    repeat (20) step();
    check("t4_rise", longint'(rise_b_n - r0), 1);
    check("t4_done_once", longint'(done_b_n - d0), 1);
    check("t4_en_cycles", longint'(en_b_n - e0), 72);
    check("t4_ts_final", longint'(ts_b), g0 + 7);

    // 5: zero-length request
    e0 = en_b_n; d0 = done_b_n; a0 = addrs_b.size();
    pulse_b(0);
    check("t5_done_hi", longint'(done_b), 1);
    check("t5_busy", longint'(busy_b), 0);
    step();
    check("t5_done_lo", longint'(done_b), 0);
    repeat (5) step();
    check("t5_no_en", longint'(en_b_n - e0), 0);
    check("t5_no_rd", longint'(addrs_b.size() - a0), 0);
    check("t5_done_once", longint'(done_b_n - d0), 1);

    // 6: reset in the middle of data, then a clean 60-byte frame
    d0 = done_b_n;
    pulse_b(200);
    repeat (20) step();
    check("t6_mid_en", longint'(en_b), 1);
    rst = 1'b1;
    step();
    check("t6_rst_en", longint'(en_b), 0);
    check("t6_rst_busy", longint'(busy_b), 0);
    check("t6_rst_done", longint'(done_b), 0);
    rst = 1'b0;
    repeat (5) step();
    check("t6_no_done", longint'(done_b_n - d0), 0);
    for (int i = 0; i < 60; i++) set_byte(i, 8'($urandom_range(0, 255)));
    s = cap_b.size(); e0 = en_b_n; d0 = done_b_n;
    pulse_b(60);
    wait_done_b("t6", d0, 200);
    build_exp(60, 60);
    cmp_frame("t6", cap_b, s);
    check("t6_en_cycles", longint'(en_b_n - e0), 72);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
